data_mem_mmio: RTL and testbench

//  Data-side memory stage for the single-cycle ARM core: consumes MemWrite, ALUResult (address) and WriteData,
//  and returns ReadData combinationally in the same cycle. Word RAM below MMIO_BASE; above it, a memory-mapped

---
 rtl/data_mem_mmio.sv | 160 ++++++++++++++++
 tb/tb_data_mem_mmio.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data-side memory stage for the single-cycle core.
//   Word RAM below the MMIO page, plus one MMIO page holding an LED register,
//   a free-running cycle counter and a down-counting timer with a sticky
//   expire flag that drives timer_irq.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   MemWrite   store strobe, commits at the rising edge
//   Adr        byte address; Adr[1:0] ignored (word access only)
//   WriteData  store data
//   ReadData   load data, combinational from Adr and current state
//   led        LED register contents
//   timer_irq  timer expired flag (STATUS[0])
module data_mem_mmio #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int unsigned LED_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      Adr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Register word offsets within the MMIO page (Adr[7:2]).
  localparam logic [5:0] OffLed    = 6'h00;
  localparam logic [5:0] OffCycle  = 6'h01;
  localparam logic [5:0] OffLoad   = 6'h02;
  localparam logic [5:0] OffCtrl   = 6'h03;
  localparam logic [5:0] OffValue  = 6'h04;
  localparam logic [5:0] OffStatus = 6'h05;

  logic [31:0] mem [DEPTH];

  logic          is_mmio;
  logic          page_ok;
  logic [5:0]    reg_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          mmio_we;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      load_q, load_d;
  logic             en_q, en_d;
  logic             auto_q, auto_d;
  logic [31:0]      value_q, value_d;
  logic             expired_q, expired_d;

  logic we_led, we_load, we_ctrl, we_status;
  logic expire_evt;

  logic unused_adr;
  assign unused_adr = ^Adr[1:0];

  assign is_mmio = (Adr[31:16] == MMIO_BASE[31:16]);
  assign page_ok = (Adr[15:8] == 8'h00);
  assign reg_off = Adr[7:2];
  // Upper RAM address bits are dropped, so RAM aliases across the non-MMIO space.
  assign ram_idx = Adr[AW+1:2];

  // Reset also blocks RAM stores so a store issued during reset never lands.
  assign ram_we  = MemWrite & ~is_mmio & ~reset;
  assign mmio_we = MemWrite & is_mmio & page_ok;

  assign we_led    = mmio_we & (reg_off == OffLed);
  assign we_load   = mmio_we & (reg_off == OffLoad);
  assign we_ctrl   = mmio_we & (reg_off == OffCtrl);
  assign we_status = mmio_we & (reg_off == OffStatus);

  // A LOAD write outranks an expiry in the same cycle.
  assign expire_evt = en_q & (value_q == 32'd1) & ~we_load;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= WriteData;
    end
  end

  always_comb begin
    led_d     = led_q;
    cycle_d   = cycle_q + 32'd1;
    load_d    = load_q;
    en_d      = en_q;
    auto_d    = auto_q;
    value_d   = value_q;
    expired_d = expired_q;

    if (we_led) begin
      led_d = WriteData[LED_W-1:0];
    end
    if (we_ctrl) begin
      en_d   = WriteData[0];
      auto_d = WriteData[1];
    end

    if (we_load) begin
      load_d  = WriteData;
      value_d = WriteData;
    end else if (en_q && value_q == 32'd1) begin
      value_d = auto_q ? load_q : 32'd0;
    end else if (en_q && value_q > 32'd1) begin
      value_d = value_q - 32'd1;
    end

    // Set wins over a same-cycle W1C clear.
    if (expire_evt) begin
      expired_d = 1'b1;
    end else if (we_status && WriteData[0]) begin
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      cycle_q   <= '0;
      load_q    <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      value_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      cycle_q   <= cycle_d;
      load_q    <= load_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      value_q   <= value_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (!is_mmio) begin
      ReadData = mem[ram_idx];
    end else if (page_ok) begin
      case (reg_off)
        OffLed:    ReadData = 32'(led_q);
        OffCycle:  ReadData = cycle_q;
        OffLoad:   ReadData = load_q;
        OffCtrl:   ReadData = {30'h0, auto_q, en_q};
        OffValue:  ReadData = value_q;
        OffStatus: ReadData = {31'h0, expired_q};
        default:   ReadData = 32'h0;
      endcase
    end
  end

  assign led       = led_q;
  assign timer_irq = expired_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio. Expected ReadData values are pushed
// to a scoreboard queue as each read is driven and popped when sampled.
module tb_data_mem_mmio;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_0008;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_000C;
  localparam logic [31:0] A_VALUE  = 32'hFFFF_0010;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  led;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  data_mem_mmio #(
    .DEPTH    (64),
    .MMIO_BASE(32'hFFFF_0000),
    .LED_W    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Adr      (Adr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .led      (led),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; reads settle 1ns after Adr changes.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Adr       = a;
    WriteData = d;
    cyc();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    Adr = a;
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    MemWrite = 1'b0;
    cyc();
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    logic [31:0] regs [6];
    regs = '{A_LED, A_CYCLE, A_LOAD, A_CTRL, A_VALUE, A_STATUS};
    do_reset();
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL reset_led: got %h exp 00", led);
    end
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b exp 0", timer_irq);
    end
    for (int i = 0; i < 6; i++) begin
      rd(regs[i], 32'h0);
      e = sb.pop_front();
      checks++;
      if (ReadData !== e) begin
        errors++; $display("FAIL reset_reg%0d: got %h exp %h", i, ReadData, e);
      end
    end
  endtask

  task automatic test_ram();
    logic [31:0] e;
    logic [31:0] model [6];
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL ram_rd10: got %h exp %h", ReadData, e);
    end
    rd(32'h0000_0012, 32'hDEAD_BEEF);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL ram_rd12: got %h exp %h", ReadData, e);
    end
    for (int i = 0; i < 6; i++) begin
      model[i] = $urandom;
      do_write(32'h40 + 32'(i * 4), model[i]);
    end
    for (int i = 0; i < 6; i++) begin
      rd(32'h40 + 32'(i * 4), model[i]);
      e = sb.pop_front(); checks++;
      if (ReadData !== e) begin
        errors++; $display("FAIL ram_burst%0d: got %h exp %h", i, ReadData, e);
      end
      cyc();
    end
  endtask

  task automatic test_alias();
    logic [31:0] e;
    do_write(32'h0000_0100, 32'd5);
    rd(32'h0000_0000, 32'd5);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL alias_rd0: got %h exp %h", ReadData, e);
    end
    do_write(32'hFFFF_0020, 32'd123);
    rd(32'hFFFF_0020, 32'h0);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL unmapped_rd: got %h exp %h", ReadData, e);
    end
    // Offset 0 but Adr[15:8] != 0: must not hit the LED register.
    do_write(32'hFFFF_0100, 32'h77);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL unmapped_page_led: got %h exp 00", led);
    end
    rd(32'hFFFF_0100, 32'h0);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL unmapped_page_rd: got %h exp %h", ReadData, e);
    end
  endtask

  task automatic test_led();
    logic [31:0] e;
    do_write(A_LED, 32'h1A5);
    checks++;
    if (led !== 8'hA5) begin
      errors++; $display("FAIL led_out: got %h exp a5", led);
    end
    rd(A_LED, 32'hA5);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL led_rd: got %h exp %h", ReadData, e);
    end
    // Reset with a concurrent LED store: reset wins.
    reset = 1'b1; MemWrite = 1'b1; Adr = A_LED; WriteData = 32'hFF;
    cyc();
    reset = 1'b0; MemWrite = 1'b0;
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL led_reset: got %h exp 00", led);
    end
    rd(A_CYCLE, 32'h0);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL cycle_after_reset: got %h exp %h", ReadData, e);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] e;
    do_reset();
    repeat (10) cyc();
    rd(A_CYCLE, 32'd10);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL cycle10: got %h exp %h", ReadData, e);
    end
    do_write(A_CYCLE, 32'h1234);
    rd(A_CYCLE, 32'd11);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL cycle_wr_ignored: got %h exp %h", ReadData, e);
    end
    dut.cycle_q = 32'hFFFF_FFFE;
    cyc();
    rd(A_CYCLE, 32'hFFFF_FFFF);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL cycle_max: got %h exp %h", ReadData, e);
    end
    cyc();
    rd(A_CYCLE, 32'h0);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL cycle_wrap: got %h exp %h", ReadData, e);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] e;
    logic [31:0] exp_val [5];
    logic        exp_irq [5];
    exp_val = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    do_write(A_LOAD, 32'd3);
    do_write(A_CTRL, 32'd1);
    for (int i = 0; i < 5; i++) begin
      rd(A_VALUE, exp_val[i]);
      e = sb.pop_front(); checks++;
      if (ReadData !== e) begin
        errors++; $display("FAIL oneshot_value%0d: got %h exp %h", i, ReadData, e);
      end
      checks++;
      if (timer_irq !== exp_irq[i]) begin
        errors++; $display("FAIL oneshot_irq%0d: got %b exp %b", i, timer_irq, exp_irq[i]);
      end
      cyc();
    end
    rd(A_STATUS, 32'd1);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL oneshot_status: got %h exp %h", ReadData, e);
    end
  endtask

  task automatic test_auto_w1c();
    logic [31:0] e;
    do_reset();
    do_write(A_LOAD, 32'd2);
    do_write(A_CTRL, 32'd3);
    cyc();  // VALUE 2 -> 1
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++; $display("FAIL auto_irq_pre: got %b exp 0", timer_irq);
    end
    cyc();  // VALUE 1 -> reload 2, expire
    checks++;
    if (timer_irq !== 1'b1) begin
      errors++; $display("FAIL auto_irq_first: got %b exp 1", timer_irq);
    end
    do_write(A_STATUS, 32'd1);  // non-expire cycle: clears
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++; $display("FAIL w1c_clear: got %b exp 0", timer_irq);
    end
    do_write(A_STATUS, 32'd1);  // expire cycle: set wins
    checks++;
    if (timer_irq !== 1'b1) begin
      errors++; $display("FAIL w1c_vs_expire: got %b exp 1", timer_irq);
    end
    do_write(A_STATUS, 32'd0);  // WD[0]=0 has no effect
    checks++;
    if (timer_irq !== 1'b1) begin
      errors++; $display("FAIL w1c_zero: got %b exp 1", timer_irq);
    end
    rd(A_VALUE, 32'd1);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL auto_value: got %h exp %h", ReadData, e);
    end
    cyc();  // expire again, VALUE back to 2
    do_write(A_STATUS, 32'd1);
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++; $display("FAIL w1c_clear2: got %b exp 0", timer_irq);
    end
    // VALUE is 1 here: a LOAD write outranks the expiry.
    do_write(A_LOAD, 32'd5);
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++; $display("FAIL load_over_expire: got %b exp 0", timer_irq);
    end
    rd(A_VALUE, 32'd5);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL load_value: got %h exp %h", ReadData, e);
    end
    rd(A_CTRL, 32'd3);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL ctrl_rd: got %h exp %h", ReadData, e);
    end
    do_write(A_CTRL, 32'hFFFF_FFF0);
    rd(A_CTRL, 32'd0);
    e = sb.pop_front(); checks++;
    if (ReadData !== e) begin
      errors++; $display("FAIL ctrl_mask: got %h exp %h", ReadData, e);
    end
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; Adr = 32'h0; WriteData = 32'h0;
    test_reset();
    test_ram();
    test_alias();
    test_led();
    test_cycle();
    test_oneshot();
    test_auto_w1c();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
